// File: rtl/jt12_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_timer_pkg
//  Purpose  : Shared widths, default Timer B prescale and the per-timer
//             control-priority encoding for the YM2612 timer unit.
//  Revision : 1.0  initial release
// ============================================================================
package jt12_timer_pkg;

    localparam int TA_W           = 10;  // Timer A counter width
    localparam int TB_W           = 8;   // Timer B counter width
    localparam int B_PRESCALE_DEF = 16;  // zero ticks per Timer B step

    // Per-cycle control action, highest priority first: CLR_RUN > SET_RUN > COUNT
    localparam int          CTRL_W       = 2;
    localparam logic [1:0]  CTRL_IDLE    = 2'd0;
    localparam logic [1:0]  CTRL_COUNT   = 2'd1;
    localparam logic [1:0]  CTRL_SET_RUN = 2'd2;
    localparam logic [1:0]  CTRL_CLR_RUN = 2'd3;

    // Resolve the control inputs of one timer into a single action.
    // A set_run while already running falls through to the count path.
    function automatic logic [CTRL_W-1:0] ctrl_decode(
        input logic clr_run,
        input logic set_run,
        input logic running,
        input logic tick
    );
        logic [CTRL_W-1:0] c;
        c = CTRL_IDLE;
        if (clr_run)                 c = CTRL_CLR_RUN;
        else if (set_run && !running) c = CTRL_SET_RUN;
        else if (tick && running)    c = CTRL_COUNT;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_timer_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_timer_cnt
//  Purpose  : One YM2612 timer: run bit, up-counter with preset reload,
//             optional power-of-two prescaler (PRESCALE = 1 disables it),
//             overflow pulse and IRQ flag.
//  Revision : 1.0  initial release
// ============================================================================
module jt12_timer_cnt
    import jt12_timer_pkg::*;
#(
    parameter int W        = 10,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         zero,
    input  logic [W-1:0] value,
    input  logic         set_run,
    input  logic         clr_run,
    input  logic         enable_irq,
    input  logic         clr_flag,
    output logic         flag,
    output logic         overflow,
    output logic [W-1:0] cnt
);

    logic              run_q,  run_d;
    logic [W-1:0]      cnt_q,  cnt_d;
    logic              flag_q, flag_d;
    logic              ovf_q,  ovf_d;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_step;

    assign w_ctrl = ctrl_decode(clr_run, set_run, run_q, zero);

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] pre_q, pre_d;

            // Prescaler: cleared on start, advances on every counted tick
            always_comb begin
                pre_d = pre_q;
                if (w_ctrl == CTRL_SET_RUN)
                    pre_d = '0;
                else if (w_ctrl == CTRL_COUNT)
                    pre_d = pre_q + 1'b1;
            end

            // Prescaler register
            always_ff @(posedge clk) begin
                if (rst) pre_q <= '0;
                else     pre_q <= pre_d;
            end

            // The main counter steps on the tick where the prescaler wraps
            assign w_step = (w_ctrl == CTRL_COUNT) && (pre_d == '0);
        end else begin : g_nopre
            assign w_step = (w_ctrl == CTRL_COUNT);
        end
    endgenerate

    // Next-state for run bit, counter, overflow pulse and flag
    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        flag_d = flag_q;
        case (w_ctrl)
            CTRL_CLR_RUN: run_d = 1'b0;
            CTRL_SET_RUN: begin
                run_d = 1'b1;
                cnt_d = value;
            end
            CTRL_COUNT: begin
                if (w_step) begin
                    if (cnt_q == {W{1'b1}}) begin
                        cnt_d = value;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // A flag-setting overflow beats a simultaneous clear
        if (ovf_d && enable_irq)
            flag_d = 1'b1;
        else if (clr_flag)
            flag_d = 1'b0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign flag     = flag_q;
    assign overflow = ovf_q;
    assign cnt      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/jt12_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_timer_unit
//  Purpose  : YM2612 Timer A (10-bit) and Timer B (8-bit, prescaled),
//             status flags, CSM overflow pulse and active-low IRQ.
//  Options  : JT12_TIMER_READBACK_EN adds cnt_A / cnt_B live counter ports.
//  Revision : 1.0  initial release
// ============================================================================
module jt12_timer_unit
    import jt12_timer_pkg::*;
#(
    parameter int B_PRESCALE = B_PRESCALE_DEF  // must be a power of two
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            zero,
    input  logic [TA_W-1:0] value_A,
    input  logic [TB_W-1:0] value_B,
    input  logic            set_run_A,
    input  logic            set_run_B,
    input  logic            clr_run_A,
    input  logic            clr_run_B,
    input  logic            enable_irq_A,
    input  logic            enable_irq_B,
    input  logic            clr_flag_A,
    input  logic            clr_flag_B,
    output logic            flag_A,
    output logic            flag_B,
    output logic            overflow_A,
`ifdef JT12_TIMER_READBACK_EN
    output logic [TA_W-1:0] cnt_A,
    output logic [TB_W-1:0] cnt_B,
`endif
    output logic            irq_n
);

    logic [TA_W-1:0] w_cnt_A;
    logic [TB_W-1:0] w_cnt_B;
    logic            w_ovf_B_unused;  // Timer B overflow has no consumer

    jt12_timer_cnt #(
        .W        (TA_W),
        .PRESCALE (1)
    ) u_timer_a (
        .clk        (clk),
        .rst        (rst),
        .zero       (zero),
        .value      (value_A),
        .set_run    (set_run_A),
        .clr_run    (clr_run_A),
        .enable_irq (enable_irq_A),
        .clr_flag   (clr_flag_A),
        .flag       (flag_A),
        .overflow   (overflow_A),
        .cnt        (w_cnt_A)
    );

    jt12_timer_cnt #(
        .W        (TB_W),
        .PRESCALE (B_PRESCALE)
    ) u_timer_b (
        .clk        (clk),
        .rst        (rst),
        .zero       (zero),
        .value      (value_B),
        .set_run    (set_run_B),
        .clr_run    (clr_run_B),
        .enable_irq (enable_irq_B),
        .clr_flag   (clr_flag_B),
        .flag       (flag_B),
        .overflow   (w_ovf_B_unused),
        .cnt        (w_cnt_B)
    );

`ifdef JT12_TIMER_READBACK_EN
    assign cnt_A = w_cnt_A;
    assign cnt_B = w_cnt_B;
`else
    logic w_cnt_unused;
    assign w_cnt_unused = ^{w_cnt_A, w_cnt_B};
`endif

    // IRQ is combinational from the registered flags
    assign irq_n = ~(flag_A | flag_B);

endmodule
`default_nettype wire

// File: tb/tb_jt12_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt12_timer_unit
//  Purpose  : Self-checking bench for jt12_timer_unit (vector table plus
//             directed multi-cycle sequences).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt12_timer_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic [9:0] value_A = '0;
    logic [7:0] value_B = '0;
    logic       set_run_A = 1'b0, set_run_B = 1'b0;
    logic       clr_run_A = 1'b0, clr_run_B = 1'b0;
    logic       enable_irq_A = 1'b0, enable_irq_B = 1'b0;
    logic       clr_flag_A = 1'b0, clr_flag_B = 1'b0;
    logic       flag_A, flag_B, overflow_A, irq_n;
`ifdef JT12_TIMER_READBACK_EN
    logic [9:0] cnt_A;
    logic [7:0] cnt_B;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jt12_timer_unit #(.B_PRESCALE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .zero         (zero),
        .value_A      (value_A),
        .value_B      (value_B),
        .set_run_A    (set_run_A),
        .set_run_B    (set_run_B),
        .clr_run_A    (clr_run_A),
        .clr_run_B    (clr_run_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .overflow_A   (overflow_A),
`ifdef JT12_TIMER_READBACK_EN
        .cnt_A        (cnt_A),
        .cnt_B        (cnt_B),
`endif
        .irq_n        (irq_n)
    );

    typedef struct {
        logic       rst, zero, set_A, clr_A, en_A, clrf_A;
        logic [9:0] vA;
        logic       e_flag_A, e_ovf_A, e_irq_n;
    } vec_t;

    // c = {rst, zero, set_run_A, clr_run_A, enable_irq_A, clr_flag_A}
    // e = {flag_A, overflow_A, irq_n}
    function automatic vec_t mk(input logic [5:0] c, input logic [2:0] e);
        vec_t v;
        {v.rst, v.zero, v.set_A, v.clr_A, v.en_A, v.clrf_A} = c;
        v.vA = 10'd1023;
        {v.e_flag_A, v.e_ovf_A, v.e_irq_n} = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic tick();
        zero = 1'b1;
        clk1();
        zero = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        enable_irq_A = 1'b0;
        enable_irq_B = 1'b0;
    endtask

    task automatic start_A();
        set_run_A = 1'b1;
        clk1();
        set_run_A = 1'b0;
    endtask

    vec_t vt[17];

    initial begin
        int ovf_seen;
        int ticks;

        // ---------------- vector table (one clock per row) ----------------
        vt[0]  = mk(6'b100000, 3'b001);  // reset state
        vt[1]  = mk(6'b001000, 3'b001);  // start A, preset 1023
        vt[2]  = mk(6'b010000, 3'b011);  // overflow every tick, irq disabled
        vt[3]  = mk(6'b010000, 3'b011);
        vt[4]  = mk(6'b000000, 3'b001);  // pulse lasts one cycle
        vt[5]  = mk(6'b010011, 3'b110);  // clear/set race: set wins
        vt[6]  = mk(6'b000011, 3'b001);  // lone clear
        vt[7]  = mk(6'b010010, 3'b110);  // flag set again
        vt[8]  = mk(6'b000000, 3'b100);  // disabling irq keeps the flag
        vt[9]  = mk(6'b010100, 3'b100);  // stop beats tick
        vt[10] = mk(6'b010000, 3'b100);  // stopped: no count
        vt[11] = mk(6'b000001, 3'b001);  // flag clearable while stopped
        vt[12] = mk(6'b011000, 3'b001);  // start tick is not counted
        vt[13] = mk(6'b010000, 3'b011);
        vt[14] = mk(6'b011000, 3'b011);  // set_run while running just counts
        vt[15] = mk(6'b110000, 3'b001);  // reset wins over overflow
        vt[16] = mk(6'b010000, 3'b001);  // stopped after reset

        clk1();
        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rst; zero = vt[i].zero;
            set_run_A = vt[i].set_A; clr_run_A = vt[i].clr_A;
            enable_irq_A = vt[i].en_A; clr_flag_A = vt[i].clrf_A;
            value_A = vt[i].vA;
            clk1();
            check($sformatf("vec%0d flag_A", i), 32'(flag_A), 32'(vt[i].e_flag_A));
            check($sformatf("vec%0d overflow_A", i), 32'(overflow_A), 32'(vt[i].e_ovf_A));
            check($sformatf("vec%0d irq_n", i), 32'(irq_n), 32'(vt[i].e_irq_n));
            check($sformatf("vec%0d flag_B", i), 32'(flag_B), 32'd0);
        end
        rst = 1'b0; zero = 1'b0; set_run_A = 1'b0; clr_run_A = 1'b0;
        enable_irq_A = 1'b0; clr_flag_A = 1'b0;

        // ---------------- Timer A basic: period 4 ticks ----------------
        do_reset();
        value_A = 10'd1020; enable_irq_A = 1'b1;
        start_A();
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            tick();
            check($sformatf("A_basic tick%0d ovf", k), 32'(overflow_A), 32'((k == 4) || (k == 8)));
            if (k < 4) check($sformatf("A_basic tick%0d flag", k), 32'(flag_A), 32'd0);
            if (k == 4) begin
                check("A_basic flag", 32'(flag_A), 32'd1);
                check("A_basic irq_n", 32'(irq_n), 32'd0);
            end
            clk1();
            check($sformatf("A_basic tick%0d ovf_drop", k), 32'(overflow_A), 32'd0);
            idle(21);
        end

        // ---------------- Timer B prescale: flag after tick 32 ----------------
        do_reset();
        value_B = 8'd254; enable_irq_B = 1'b1;
        set_run_B = 1'b1; clk1(); set_run_B = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k >= 15) check($sformatf("B_pre tick%0d flag_B", k), 32'(flag_B), 32'(k >= 32));
            idle(3);
        end
        check("B_pre flag_A", 32'(flag_A), 32'd0);
        check("B_pre irq_n", 32'(irq_n), 32'd0);
        clr_flag_B = 1'b1; clk1(); clr_flag_B = 1'b0;
        check("B_pre clr flag_B", 32'(flag_B), 32'd0);

        // ---------------- Stop / restart ----------------
        do_reset();
        value_A = 10'd1020; enable_irq_A = 1'b1;
        start_A();
        tick();                                  // cnt = 1021
        clr_run_A = 1'b1; clk1(); clr_run_A = 1'b0;
        ovf_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (overflow_A) ovf_seen++;
        end
        check("stop no_ovf", 32'(ovf_seen), 32'd0);
        check("stop flag", 32'(flag_A), 32'd0);
        value_A = 10'd1000;
        start_A();
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (!overflow_A && ticks < 40);
        check("restart period", 32'(ticks), 32'd24);
        // mid-period set_run must not restart the count
        for (int k = 0; k < 10; k++) tick();
        start_A();
        ticks = 10;
        do begin
            tick();
            ticks++;
        end while (!overflow_A && ticks < 60);
        check("no_restart period", 32'(ticks), 32'd24);

        // ---------------- Reset one cycle before overflow ----------------
        do_reset();
        value_A = 10'd1020; enable_irq_A = 1'b1;
        start_A();
        for (int k = 0; k < 3; k++) tick();    // cnt = 1023
        rst = 1'b1; zero = 1'b1;
        clk1();
        rst = 1'b0; zero = 1'b0;
        check("rst ovf", 32'(overflow_A), 32'd0);
        check("rst flag_A", 32'(flag_A), 32'd0);
        check("rst irq_n", 32'(irq_n), 32'd1);
`ifdef JT12_TIMER_READBACK_EN
        check("rst cnt_A", 32'(cnt_A), 32'd0);
        check("rst cnt_B", 32'(cnt_B), 32'd0);
`endif
        ovf_seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (overflow_A) ovf_seen++;
        end
        check("rst stopped", 32'(ovf_seen), 32'd0);
        check("rst stopped flag", 32'(flag_A), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/jt12_timer_unit.md
Name: jt12_timer_unit

Overview:
- Implements the YM2612 Timer A (10-bit) and Timer B (8-bit, prescaled) downstream of the register map block.
- Consumes the timer value, run, load, IRQ-enable and flag-clear controls that the register map decodes from writes to registers 0x24–0x27.
- Produces `flag_A` and `overflow_A`, which feed back into the register map (CSM key-on path), plus the status flags and the chip IRQ line.
- Counts once per FM sample, on the `zero` pulse from the operator sequencer.

Parameters:
- B_PRESCALE, 16, number of `zero` ticks per Timer B count step; must be a power of two.

Ports:
- `clk`  in  1  system clock (Phi 1)
- `rst`  in  1  synchronous reset, active-high
- `zero`  in  1  one-cycle pulse, once per FM sample; the timer time base
- `value_A`  in  10  Timer A preset
- `value_B`  in  8  Timer B preset
- `set_run_A`, `set_run_B`  in  1  one-cycle pulse: start timer
- `clr_run_A`, `clr_run_B`  in  1  one-cycle pulse: stop timer
- `enable_irq_A`, `enable_irq_B`  in  1  level: overflow may set the flag
- `clr_flag_A`, `clr_flag_B`  in  1  one-cycle pulse: clear flag
- `flag_A`, `flag_B`  out  1  status flags (status register bits 0/1)
- `overflow_A`  out  1  one-cycle pulse on every Timer A overflow (CSM)
- `irq_n`  out  1  active-low interrupt = ~(`flag_A` | `flag_B`)

Behaviour:
- Reset values: `flag_A` = `flag_B` = 0, `overflow_A` = 0, `irq_n` = 1. Both run bits = 0, both counters = 0, prescaler = 0.
- All state updates on posedge `clk`. All outputs are registered, except `irq_n`, which is combinational from the flag registers.
- Per timer, control priority (highest first):
  - `clr_run`: run <= 0; counter is held.
  - `set_run` while stopped: run <= 1; counter <= value; Timer B prescaler <= 0. That cycle's `zero` tick is not counted.
  - `set_run` while already running: no effect (no restart).
  - Otherwise, `zero` && run: count step.
- Timer A count step:
  - If cnt == 1023: cnt <= `value_A`, overflow event.
  - Else: cnt <= cnt + 1.
  - Period = 1024 − `value_A` ticks; `value_A` = 1023 overflows on every tick.
- Timer B:
  - A log2(B_PRESCALE)-bit prescaler increments on every `zero` while running.
  - A count step occurs on the tick where the prescaler wraps to 0.
  - If cnt == 255: cnt <= `value_B`, overflow event; else cnt <= cnt + 1.
  - Period = B_PRESCALE × (256 − `value_B`) ticks.
- A preset change while running affects only the next reload.
- On an overflow event:
  - `overflow_A` is asserted for exactly the next cycle (A only), independent of `enable_irq_A`.
  - Flag <= 1 if `enable_irq` = 1.
- `clr_flag` clears the flag. If a flag-setting overflow and `clr_flag` occur in the same cycle, set wins.
- Deasserting `enable_irq` does not clear an already-set flag.
- A stopped timer keeps its counter and flag. Flags remain readable and clearable at any time.
- Reset mid-count returns everything to reset values at the next edge; no pending overflow is emitted.

Optional Feature:
- Macro: JT12_TIMER_READBACK_EN.
- Defined: adds outputs `cnt_A` [9:0] and `cnt_B` [7:0], mirroring the live counter registers (reset value 0), for the debug/test register path.
- Undefined: those ports are absent. Behaviour of all other ports is identical.

Decomposition:
- Package `jt12_timer_pkg` holds:
  - TA_W = 10, TB_W = 8
  - default B_PRESCALE
  - the control-priority encoding (CLR_RUN > SET_RUN > COUNT) as named constants
- Sub-module `jt12_timer_cnt`, instantiated twice. Parameters: width and prescale, where prescale = 1 means no prescaler. It contains run, counter, prescaler, flag and overflow logic.
- The top level handles `irq_n` and the `overflow_A` export.

Test Plan:
- Timer A basic:
  - Stimulus: `value_A` = 1020, `enable_irq_A` = 1, `set_run_A` pulse, then `zero` every 24 clk.
  - Response: `overflow_A` pulses exactly 1 clk after the 4th tick and again after the 8th; `flag_A` = 1 and `irq_n` = 0 after the 4th tick.
- Timer B prescale:
  - Stimulus: `value_B` = 254, `enable_irq_B` = 1, start.
  - Response: `flag_B` rises after the 32nd `zero` tick and not before; `flag_A` stays 0.
- IRQ disabled:
  - Stimulus: `enable_irq_A` = 0, `value_A` = 1023.
  - Response: `overflow_A` pulses every tick; `flag_A` stays 0; `irq_n` stays 1.
- Clear/set race:
  - Stimulus: `clr_flag_A` pulse in the same cycle as a flag-setting overflow.
  - Response: `flag_A` = 1 afterwards.
  - Stimulus: a later `clr_flag_A` alone.
  - Response: `flag_A` = 0.
- Stop/restart:
  - Stimulus: `clr_run_A` mid-count at cnt = 1021, 10 ticks, then `set_run_A` with `value_A` = 1000.
  - Response: no overflow while stopped; next overflow after 24 ticks.
  - Stimulus: a second `set_run_A` while running.
  - Response: does not restart the count.
- Reset mid-operation:
  - Stimulus: `rst` asserted one cycle before an overflow.
  - Response: no `overflow_A` pulse; flags 0; timers stopped; readback counters 0 when JT12_TIMER_READBACK_EN is defined.
